// File: rtl/alu_share_arbiter_if.sv
// Request/response and shared-ALU bundle for alu_share_arbiter.
// master: requesters + ALU side; slave: the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [2:0]         req_valid;
  logic [2:0]         req_ready;
  logic [5:0]         req_op;
  logic [3*WIDTH-1:0] req_a;
  logic [3*WIDTH-1:0] req_b;
  logic [2:0]         rsp_valid;
  logic [2:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
  logic               alu_start;
  logic [1:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_done;
  logic [WIDTH-1:0]   alu_result;
  logic               busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, alu_start, alu_op,
           alu_a, alu_b, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, alu_start, alu_op,
           alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Three-requester round-robin arbiter sharing one multi-cycle ALU.
// One transaction in flight; WAIT is bounded by TIMEOUT cycles.
module alu_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_grant;
  logic [1:0]       r_last_grant;
  logic [7:0]       r_timer;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic             w_any;
  logic [1:0]       w_cand0;
  logic [1:0]       w_cand1;
  logic [1:0]       w_sel;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2:0]       w_req_ready;
  logic [2:0]       w_rsp_valid;
  logic             w_alu_start;
  logic             w_busy;
  logic             w_expired;

  function automatic logic [1:0] f_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin pick: last_grant+1 first, then +2, last_grant itself last.
  always_comb begin
    w_any   = |bus.req_valid;
    w_cand0 = f_next(r_last_grant);
    w_cand1 = f_next(w_cand0);
    w_sel   = r_last_grant;
    if (bus.req_valid[w_cand1]) w_sel = w_cand1;
    if (bus.req_valid[w_cand0]) w_sel = w_cand0;
  end

  // Route the selected requester's opcode and operands.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (w_sel == k[1:0]) begin
        w_sel_op = bus.req_op[2*k +: 2];
        w_sel_a  = bus.req_a[k*WIDTH +: WIDTH];
        w_sel_b  = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_expired = (r_timer == LP_TLAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs; every output forced low while in reset.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_alu_start = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready = 3'b001 << w_sel;
          w_next      = ISSUE;
        end
      end
      ISSUE: begin
        w_alu_start = 1'b1;
        w_next      = WAIT;
      end
      WAIT: begin
        if (bus.alu_done || w_expired) w_next = RESP;
      end
      RESP: begin
        w_rsp_valid = 3'b001 << r_grant;
        if (bus.rsp_ready[r_grant]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (rst) begin
      w_req_ready = '0;
      w_rsp_valid = '0;
      w_alu_start = 1'b0;
      w_busy      = 1'b0;
    end
  end

  // Capture operands on accept, run the WAIT timer, latch the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= 2'd2;
      r_timer      <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_sel;
            r_alu_op <= w_sel_op;
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          // done takes precedence over expiry in the same cycle
          if (bus.alu_done) begin
            r_rsp_data <= bus.alu_result;
            r_rsp_err  <= 1'b0;
          end else if (w_expired) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[r_grant]) r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.alu_start = w_alu_start;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.busy      = w_busy;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT, 16, max WAIT cycles before abort; legal range 2..255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  3  per-requester request valid; requester i = bit i.
REQ-006 req_ready  out  3  per-requester accept; at most one bit high.
REQ-007 req_op  in  6  opcode, requester i at bits [2i+1:2i].
REQ-008 req_a, req_b  in  3*WIDTH  operands, requester i at bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-009 rsp_valid  out  3  per-requester response valid; at most one bit high.
REQ-010 rsp_ready  in  3  per-requester response accept.
REQ-011 rsp_data  out  WIDTH  shared response data.
REQ-012 rsp_err  out  1  response is a timeout abort.
REQ-013 alu_start  out  1  one-cycle launch pulse to the shared ALU.
REQ-014 alu_op  out  2; alu_a, alu_b  out  WIDTH  registered ALU operands.
REQ-015 alu_done  in  1; alu_result  in  WIDTH  ALU completion and result.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any req_valid, select g by round-robin: priority order last_grant+1, last_grant+2, last_grant (mod 3).
REQ-019 IDLE: req_ready[g] is asserted combinationally in the same cycle. On that edge, req_op/a/b of g are captured into alu_op/a/b, g is stored, and the FSM moves to ISSUE.
REQ-020 req_ready is 0 in every state except IDLE; non-selected requesters hold their requests.
REQ-021 ISSUE: alu_start=1 for exactly one cycle; WAIT timer cleared to 0; next state WAIT.
REQ-022 WAIT: if alu_done=1, alu_result is captured into rsp_data with rsp_err=0, and the FSM goes to RESP. This is legal from the first WAIT cycle onward.
REQ-023 WAIT: otherwise the timer increments. When the timer equals TIMEOUT-1 without alu_done, the FSM goes to RESP with rsp_data=0 and rsp_err=1.
REQ-024 alu_done and timer expiry in the same cycle: done wins, rsp_err=0.
REQ-025 alu_done outside WAIT is ignored.
REQ-026 RESP: rsp_valid[g]=1. rsp_data and rsp_err are held stable until rsp_ready[g]=1. On that edge: last_grant<=g, next state IDLE.
REQ-027 rsp_ready bits other than g are ignored.
REQ-028 alu_op/a/b hold their last captured value until the next capture.
REQ-029 Minimum transaction period: 4 cycles (accept, ISSUE, 1 WAIT, 1 RESP). A new accept is possible in the cycle after the RESP handshake.
REQ-030 Requests arriving during a busy transaction are only arbitrated on return to IDLE.

Reset
REQ-031 When rst=1 at a clock edge: state=IDLE, last_grant=2 (requester 0 highest priority first), timer=0.
REQ-032 Reset values of all other registers: alu_op/a/b=0, rsp_data=0, rsp_err=0, stored g=0.
REQ-033 While rst=1, all outputs read 0: req_ready=0, rsp_valid=0, alu_start=0, busy=0.
REQ-034 Reset asserted mid-transaction (any state) aborts it. No response is issued and no alu_start is issued afterward. The requester must re-present its request.

Verification
REQ-035 Single request. Stimulus: after reset, req_valid=001, op=2, a=0x12, b=0x34; alu_done one cycle after alu_start with result=0x46. Required: req_ready=001 same cycle; alu_start next cycle with alu_a=0x12, alu_b=0x34; rsp_valid=001, rsp_data=0x46, rsp_err=0.
REQ-036 Round-robin fairness. Stimulus: req_valid=111 held continuously; rsp_ready=111. Required: grant order 0,1,2,0,1,2; no requester granted twice before the others are served.
REQ-037 Timeout. Stimulus: TIMEOUT=16; alu_done never asserted. Required: RESP entered after 16 WAIT cycles; rsp_data=0, rsp_err=1; the next transaction still completes normally.
REQ-038 Response backpressure. Stimulus: rsp_ready[g]=0 for 5 cycles, with req_valid on other requesters. Required: rsp_valid[g], rsp_data and rsp_err stable for all 5 cycles; req_ready=000; no alu_start.
REQ-039 Mid-transaction reset. Stimulus: rst pulsed for 1 cycle during WAIT, then alu_done=1. Required: done ignored; all outputs 0; the next request goes to requester 0 first.
REQ-040 Simultaneous events. Stimulus: alu_done=1 in the cycle the timer reaches TIMEOUT-1, with result=0xA5. Required: rsp_data=0xA5, rsp_err=0.
